coeff_pair_mac: RTL and testbench
=================================

Name: coeff_pair_mac

Overview:
- Pipelined multiply-accumulate stage that sits directly upstream of the mod-7681 prime reducer.
- Computes a0*b0 + a1*b1 + c on coefficients of Z_7681 and emits the unreduced 27-bit sum on the reducer's 27-bit input.
- Used for base-case polynomial multiplication and matrix-vector inner products.
- c is the previous reduced partial sum fed back by the controller.

Parameters:
- Q, 7681, modulus; operands must be < Q.
- CW, 13, coefficient width.
- OW, 27, output width; 2*(Q-1)^2 + (Q-1) = 117,972,480 < 2^27.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  stage can accept operands this cycle.
- pair_en  in  1  1: include a1*b1; 0: a1*b1 term forced to 0.
- acc_en  in  1  1: include c; 0: c term forced to 0.
- a0, b0, a1, b1  in  CW each  operands.
- c  in  CW  accumulator operand.
- out_valid  out  1  sum valid.
- out_ready  in  1  consumer accepts sum.
- sum  out  OW  a0*b0 + pair_en*a1*b1 + acc_en*c, unsigned, exact (no reduction).
- range_err  out  1  sticky: some accepted operand was >= Q.

Behaviour:
- Reset (async assert, sync deassert handled at top): all pipeline valid bits 0, out_valid=0, sum=0, range_err=0. in_ready=1 once rst_n is high.
- Accept: operands are accepted on a rising edge with in_valid && in_ready. Inputs are ignored otherwise.
- Pipeline: 2 register stages, latency 2 from accept to out_valid.
  - S1 registers p0=a0*b0 (26b), p1=pair_en?a1*b1:0 (26b), cz=acc_en?c:0 (13b), v1.
  - S2 registers sum=p0+p1+cz (27b), v2=out_valid.
- Stall rule: advance = !out_valid || out_ready.
  - When advance=0, S1 and S2 hold and in_ready=0.
  - in_ready = advance; it is combinational from out_ready.
  - No bubble insertion: back-to-back accepts give back-to-back outputs, throughput 1/cycle.
- Bubbles: a stage whose valid is 0 still clocks data when advancing. sum content is don't-care while out_valid=0, but must not be X after reset.
- Output hold: while out_valid && !out_ready, sum and out_valid are stable.
- Range check: on accept, if a0, b0, or c (when acc_en) >= Q, or a1/b1 (when pair_en) >= Q, then range_err <= 1 from the next cycle. It clears only on reset. The computation proceeds unaltered. Max raw sum with 13-bit operands is 2*8191^2+8191 = 134,193,153 < 2^27, so there is no overflow in any case.
- Flush: no flush input. Reset mid-operation drops all in-flight sums immediately (out_valid=0 asynchronously).
- Downstream contract: sum feeds the reducer's in port. The reducer registers in each clk, so the consumer treats its result as valid one cycle after the out_valid&&out_ready handshake.

Decomposition:
- Shared package holds: KEM_Q=7681, COEFF_W=13, MAC_W=27, 2*Q=15362, 3*Q=23043 (the reducer's correction thresholds). Both blocks import these constants.
- One sub-module: coeff_mult (registered 13x13 unsigned multiplier with enable), instantiated twice in S1.

Test Plan:
- Reset then single op: a0=7680, b0=7680, a1=7680, b1=7680, c=7680, pair_en=acc_en=1, out_ready=1 -> out_valid exactly 2 cycles after accept, sum=117,972,480, range_err=0.
- Mode masking: a0=3, b0=5, a1=100, b1=100, c=9 with pair_en=0, acc_en=0 -> sum=15; with pair_en=1, acc_en=1 -> sum=10,024.
- Back-to-back stream of 64 random in-range sets, out_ready=1 -> 64 consecutive out_valid cycles, each sum matches the model, order preserved.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 during the stall, sum held. On release, no loss and no duplication (count accepted == count emitted).
- Range error: accept a0=7681 -> sum=7681*b0 (computed exactly), range_err=1 next cycle and stays 1. Then a0=8191 with pair_en=0 and a1=8000 -> a1 is not flagged.
- Async reset mid-stream: drop rst_n with two sums in flight -> out_valid=0, range_err=0 immediately. After release, the first new accept emits the correct sum with no stale data.

Source files
------------

// File: rtl/coeff_pair_mac_pkg.sv
// Shared constants for the Z_7681 multiply-accumulate stage and the mod-7681 reducer it feeds.
package coeff_pair_mac_pkg;

    localparam int KEM_Q   = 7681;
    localparam int COEFF_W = 13;
    localparam int MAC_W   = 27;
    localparam int PROD_W  = 2 * COEFF_W;

    // Correction thresholds used by the downstream reducer.
    localparam int KEM_2Q  = 2 * KEM_Q;
    localparam int KEM_3Q  = 3 * KEM_Q;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [PROD_W-1:0]  prod_t;
    typedef logic [MAC_W-1:0]   mac_t;

endpackage

// File: rtl/coeff_pair_mac_mult.sv
// Registered unsigned W x W multiplier; the product updates only while en is high.
module coeff_mult #(
    parameter int W = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
        end else if (en) begin
            p_reg <= (2*W)'(a) * (2*W)'(b);
        end
    end

    assign p = p_reg;

endmodule

// File: rtl/coeff_pair_mac.sv
// Two-stage a0*b0 + a1*b1 + c pipeline producing the exact unreduced sum for the mod-7681 reducer.
module coeff_pair_mac
    import coeff_pair_mac_pkg::*;
#(
    parameter int Q  = KEM_Q,
    parameter int CW = COEFF_W,
    parameter int OW = MAC_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          pair_en,
    input  logic          acc_en,
    input  logic [CW-1:0] a0,
    input  logic [CW-1:0] b0,
    input  logic [CW-1:0] a1,
    input  logic [CW-1:0] b1,
    input  logic [CW-1:0] c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] sum,
    output logic          range_err
);

    localparam logic [CW-1:0] Q_C = CW'(Q);

    logic          advance;
    logic          accept;
    logic          oob;
    logic [CW-1:0] a1_gated;
    logic [CW-1:0] c_gated;

    logic [2*CW-1:0] p0;
    logic [2*CW-1:0] p1;

    logic [CW-1:0] cz_reg;
    logic          v1_reg;
    logic [OW-1:0] sum_reg;
    logic          v2_reg;
    logic          range_err_reg;

    // Whole pipeline moves in lockstep: it stalls only when a held result is not taken.
    assign advance  = !v2_reg || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // Masking one multiplicand is enough to force the a1*b1 term to zero.
    assign a1_gated = pair_en ? a1 : '0;
    assign c_gated  = acc_en  ? c  : '0;

    assign oob = (a0 >= Q_C) || (b0 >= Q_C)
               || (acc_en  && (c  >= Q_C))
               || (pair_en && ((a1 >= Q_C) || (b1 >= Q_C)));

    coeff_mult #(.W(CW)) u_mult0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .a     (a0),
        .b     (b0),
        .p     (p0)
    );

    coeff_mult #(.W(CW)) u_mult1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .a     (a1_gated),
        .b     (b1),
        .p     (p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cz_reg        <= '0;
            v1_reg        <= 1'b0;
            sum_reg       <= '0;
            v2_reg        <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            if (advance) begin
                cz_reg  <= c_gated;
                v1_reg  <= accept;
                sum_reg <= OW'(p0) + OW'(p1) + OW'(cz_reg);
                v2_reg  <= v1_reg;
            end
            if (accept && oob) begin
                range_err_reg <= 1'b1;
            end
        end
    end

    assign out_valid = v2_reg;
    assign sum       = sum_reg;
    assign range_err = range_err_reg;

endmodule

// File: tb/tb_coeff_pair_mac.sv
// Self-checking bench for coeff_pair_mac: directed table, random stream, backpressure, range and reset cases.
module tb_coeff_pair_mac;

    typedef struct {
        logic [12:0] a0, b0, a1, b1, c;
        logic        pe, ae;
        int unsigned exp_sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pair_en = 1'b0;
    logic        acc_en = 1'b0;
    logic [12:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, c = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [26:0] sum;
    logic        range_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_emit   = 0;
    int cyc      = 0;
    int first_emit = -1;
    int last_emit  = -1;
    bit err_model  = 0;
    int unsigned exp_q[$];
    vec_t tbl[7];

    coeff_pair_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pair_en   (pair_en),
        .acc_en    (acc_en),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    function automatic int unsigned model_sum(input vec_t v);
        int unsigned s;
        s = int'(v.a0) * int'(v.b0);
        if (v.pe) s = s + int'(v.a1) * int'(v.b1);
        if (v.ae) s = s + int'(v.c);
        return s;
    endfunction

    function automatic bit model_oob(input vec_t v);
        return (v.a0 >= 7681) || (v.b0 >= 7681) || (v.ae && v.c >= 7681)
            || (v.pe && (v.a1 >= 7681 || v.b1 >= 7681));
    endfunction

    function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                                input int cc, input bit pe, input bit ae);
        vec_t v;
        v.a0 = 13'(x0); v.b0 = 13'(y0); v.a1 = 13'(x1); v.b1 = 13'(y1); v.c = 13'(cc);
        v.pe = pe; v.ae = ae;
        v.exp_sum = model_sum(v);
        return v;
    endfunction

    function automatic vec_t rnd();
        return mk($urandom_range(0, 7680), $urandom_range(0, 7680), $urandom_range(0, 7680),
                  $urandom_range(0, 7680), $urandom_range(0, 7680),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input logic iv, input logic ordy);
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1; c = v.c;
        pair_en = v.pe; acc_en = v.ae;
        in_valid = iv; out_ready = ordy;
    endtask

    // One clock of traffic: drive at negedge, predict the handshakes of the coming posedge.
    task automatic cycle(input vec_t v, input logic iv, input logic ordy);
        @(negedge clk);
        drive(v, iv, ordy);
        #1;
        cyc++;
        chk("in_ready", in_ready, (!out_valid || ordy) ? 1 : 0);
        chk("range_err", range_err, err_model);
        if (iv && in_ready) begin
            exp_q.push_back(v.exp_sum);
            n_acc++;
            if (model_oob(v)) err_model = 1;
        end
        if (out_valid && ordy) begin
            n_emit++;
            if (first_emit < 0) first_emit = cyc;
            last_emit = cyc;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out: got sum %0d, expected no output", sum);
            end else begin
                chk("stream_sum", sum, exp_q.pop_front());
            end
        end
        $display("cyc %0d iv=%0b ordy=%0b in_ready=%0b out_valid=%0b sum=%0d err=%0b",
                 cyc, iv, ordy, in_ready, out_valid, sum, range_err);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle(z, 1'b0, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        err_model = 0; n_acc = 0; n_emit = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_range_err", range_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{13'd7680, 13'd7680, 13'd7680, 13'd7680, 13'd7680, 1'b1, 1'b1, 117972480};
        tbl[1] = '{13'd3, 13'd5, 13'd100, 13'd100, 13'd9, 1'b0, 1'b0, 15};
        tbl[2] = '{13'd3, 13'd5, 13'd100, 13'd100, 13'd9, 1'b1, 1'b1, 10024};
        tbl[3] = '{13'd3, 13'd5, 13'd100, 13'd100, 13'd9, 1'b1, 1'b0, 10015};
        tbl[4] = '{13'd3, 13'd5, 13'd100, 13'd100, 13'd9, 1'b0, 1'b1, 24};
        tbl[5] = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 1'b1, 1'b1, 0};
        tbl[6] = '{13'd7680, 13'd1, 13'd1, 13'd7680, 13'd7680, 1'b1, 1'b1, 23040};

        apply_reset();

        // Directed table: exact 2-cycle latency and exact sum per record.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(tbl[i], 1'b1, 1'b1);
            #1;
            chk("tbl_in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("tbl_lat1_valid", out_valid, 0);
            @(negedge clk);
            #1;
            chk("tbl_lat2_valid", out_valid, 1);
            chk("tbl_sum", sum, tbl[i].exp_sum);
            chk("tbl_range_err", range_err, 0);
            $display("vec %0d a0=%0d b0=%0d a1=%0d b1=%0d c=%0d pe=%0b ae=%0b sum=%0d exp=%0d",
                     i, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].c,
                     tbl[i].pe, tbl[i].ae, sum, tbl[i].exp_sum);
        end
        idle(2);

        // Back-to-back random stream.
        n_acc = 0; n_emit = 0; first_emit = -1; last_emit = -1;
        for (int i = 0; i < 64; i++) cycle(rnd(), 1'b1, 1'b1);
        idle(4);
        chk("b2b_accepted", n_acc, 64);
        chk("b2b_emitted", n_emit, 64);
        chk("b2b_span", last_emit - first_emit + 1, 64);

        // Backpressure: stall 5 cycles with in_valid held high.
        n_acc = 0; n_emit = 0;
        for (int i = 0; i < 3; i++) cycle(rnd(), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(rnd(), 1'b1, 1'b0);
            #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            if (exp_q.size() > 0) chk("stall_sum_hold", sum, exp_q[0]);
        end
        idle(6);
        chk("bp_no_loss", n_emit, n_acc);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Range error: sticky flag, computation unaltered.
        cycle(mk(7681, 3, 0, 0, 0, 0, 0), 1'b1, 1'b1);
        idle(3);
        chk("oob_flag_set", range_err, 1);
        idle(2);
        chk("oob_flag_sticky", range_err, 1);

        apply_reset();
        cycle(mk(10, 10, 8000, 8191, 8191, 0, 0), 1'b1, 1'b1);
        idle(3);
        chk("masked_oob_clear", range_err, 0);
        cycle(mk(8191, 2, 8000, 5, 0, 0, 0), 1'b1, 1'b1);
        idle(3);
        chk("oob_a0_8191", range_err, 1);

        // Async reset with two sums in flight.
        apply_reset();
        cycle(mk(8000, 2, 1, 1, 0, 1, 0), 1'b1, 1'b1);
        cycle(mk(4, 4, 0, 0, 0, 0, 0), 1'b1, 1'b1);
        #2;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_err", range_err, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_err", range_err, 0);
        exp_q.delete();
        err_model = 0; n_acc = 0; n_emit = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        cycle(mk(1234, 5678, 7000, 2, 77, 1, 1), 1'b1, 1'b1);
        idle(4);
        chk("post_rst_emitted", n_emit, 1);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
